// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 key tracking path:
//               set-2 scan-code constants, move-code constants, the prefix
//               FSM state type and small move-code helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Prefix / special scan bytes
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;

    // Non-extended game keys
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Extended (E0-prefixed) arrow keys
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Move codes
    localparam logic [2:0] MV_NONE   = 3'b000;
    localparam logic [2:0] MV_UP     = 3'b001;
    localparam logic [2:0] MV_LEFT   = 3'b010;
    localparam logic [2:0] MV_DOWN   = 3'b011;
    localparam logic [2:0] MV_RIGHT  = 3'b100;
    localparam logic [2:0] MV_ACTION = 3'b101;

    // Prefix-tracking FSM
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } ps2_state_e;

    // Held-bitmap position of a move code: bit (code-1); none maps to zero.
    function automatic logic [4:0] mv_to_onehot(input logic [2:0] code);
        logic [4:0] oh;
        oh = 5'b00000;
        case (code)
            MV_UP:     oh = 5'b00001;
            MV_LEFT:   oh = 5'b00010;
            MV_DOWN:   oh = 5'b00100;
            MV_RIGHT:  oh = 5'b01000;
            MV_ACTION: oh = 5'b10000;
            default:   oh = 5'b00000;
        endcase
        return oh;
    endfunction

    // Fixed priority: up > left > down > right > action.
    function automatic logic [2:0] prio_move(input logic [4:0] held);
        logic [2:0] mv;
        if (held[0])      mv = MV_UP;
        else if (held[1]) mv = MV_LEFT;
        else if (held[2]) mv = MV_DOWN;
        else if (held[3]) mv = MV_RIGHT;
        else if (held[4]) mv = MV_ACTION;
        else              mv = MV_NONE;
        return mv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keymap.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keymap
// Description : Combinational scan-code map. Translates {extended, byte}
//               into a hit flag, the 3-bit move code and the one-hot
//               held-bitmap position.
// Ports       : ext_i     - byte was preceded by E0
//               byte_i    - scan byte
//               hit_o     - byte is a tracked game key
//               code_o    - move code (MV_NONE when no hit)
//               onehot_o  - held-bitmap bit for the key (zero when no hit)
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] byte_i,
    output logic       hit_o,
    output logic [2:0] code_o,
    output logic [4:0] onehot_o
);

    always_comb begin
        code_o = MV_NONE;
        if (!ext_i) begin
            case (byte_i)
                SC_W:     code_o = MV_UP;
                SC_A:     code_o = MV_LEFT;
                SC_S:     code_o = MV_DOWN;
                SC_D:     code_o = MV_RIGHT;
                SC_SPACE: code_o = MV_ACTION;
                default:  code_o = MV_NONE;
            endcase
        end else begin
            case (byte_i)
                SC_UP:    code_o = MV_UP;
                SC_LEFT:  code_o = MV_LEFT;
                SC_DOWN:  code_o = MV_DOWN;
                SC_RIGHT: code_o = MV_RIGHT;
                default:  code_o = MV_NONE;
            endcase
        end
        hit_o    = (code_o != MV_NONE);
        onehot_o = mv_to_onehot(code_o);
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_tracker
// Description : Tracks PS/2 set-2 make/break/extended sequences for the game
//               keys, keeps a held-key bitmap, and produces a registered move
//               code plus a one-cycle pulse on each genuine new press.
//               Typematic repeats of an already-held key are ignored.
// Ports       : clk          - system clock
//               resetn       - asynchronous active-low reset
//               rx_done_tick - one-cycle strobe, rx_data holds a new byte
//               rx_data      - received scan byte
//               held         - held bitmap {action,right,down,left,up}
//               move         - current move code
//               press_tick   - one-cycle pulse on a new press
//               press_code   - move code of the last new press
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic [4:0] held,
    output logic [2:0] move,
    output logic       press_tick,
    output logic [2:0] press_code
);

    localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       wasd_q, wasd_d;     // WASD + Space
    logic [4:0]       arrow_q, arrow_d;   // E0 arrows
    logic [4:0]       held_q, held_d;
    logic [2:0]       move_q, move_d;
    logic             press_tick_q, press_tick_d;
    logic [2:0]       press_code_q, press_code_d;

    logic             w_ext;
    logic             w_is_make;
    logic             w_is_break;
    logic             w_hit;
    logic [2:0]       w_code;
    logic [4:0]       w_oh;

    // Extended-ness is a property of the state the byte arrives in.
    assign w_ext = (state_q == ST_GOT_E0) || (state_q == ST_GOT_E0F0);

    ps2_keymap u_keymap (
        .ext_i    (w_ext),
        .byte_i   (rx_data),
        .hit_o    (w_hit),
        .code_o   (w_code),
        .onehot_o (w_oh)
    );

    // Prefix FSM and timeout counter. A byte on the expiry cycle takes
    // precedence because the tick branch is evaluated first.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_is_make  = 1'b0;
        w_is_break = 1'b0;
        if (rx_done_tick) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_E0)      state_d = ST_GOT_E0;
                    else if (rx_data == SC_F0) state_d = ST_GOT_F0;
                    else if (rx_data != SC_E1) w_is_make = 1'b1;
                end
                ST_GOT_E0: begin
                    if (rx_data == SC_F0) begin
                        state_d = ST_GOT_E0F0;
                    end else if (rx_data != SC_E0) begin
                        w_is_make = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_GOT_F0, ST_GOT_E0F0: begin
                    w_is_break = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == TIMEOUT_VAL) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Key vectors, press pulse and move selection, all from next-state
    // values so every output updates in the cycle after the byte.
    always_comb begin
        wasd_d       = wasd_q;
        arrow_d      = arrow_q;
        press_tick_d = 1'b0;
        press_code_d = press_code_q;

        if (w_is_make && w_hit) begin
            if (w_ext) begin
                if ((arrow_q & w_oh) == 5'b00000) begin
                    arrow_d      = arrow_q | w_oh;
                    press_tick_d = 1'b1;
                    press_code_d = w_code;
                end
            end else begin
                if ((wasd_q & w_oh) == 5'b00000) begin
                    wasd_d       = wasd_q | w_oh;
                    press_tick_d = 1'b1;
                    press_code_d = w_code;
                end
            end
        end

        if (w_is_break && w_hit) begin
            if (w_ext) arrow_d = arrow_q & ~w_oh;
            else       wasd_d  = wasd_q  & ~w_oh;
        end

        held_d = wasd_d | arrow_d;

        // press_code doubles as the last-pressed key record.
        if ((held_d & mv_to_onehot(press_code_d)) != 5'b00000)
            move_d = press_code_d;
        else
            move_d = prio_move(held_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wasd_q       <= 5'b00000;
            arrow_q      <= 5'b00000;
            held_q       <= 5'b00000;
            move_q       <= MV_NONE;
            press_tick_q <= 1'b0;
            press_code_q <= MV_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wasd_q       <= wasd_d;
            arrow_q      <= arrow_d;
            held_q       <= held_d;
            move_q       <= move_d;
            press_tick_q <= press_tick_d;
            press_code_q <= press_code_d;
        end
    end

    assign held       = held_q;
    assign move       = move_q;
    assign press_tick = press_tick_q;
    assign press_code = press_code_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_tracker
// Description : Directed scoreboard bench for ps2_key_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

    localparam int TO = 20;

    logic       clk;
    logic       resetn;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [4:0] held;
    logic [2:0] move;
    logic       press_tick;
    logic [2:0] press_code;

    typedef struct {
        string      tag;
        logic [4:0] held;
        logic [2:0] mv;
        logic       tick;
        logic [2:0] code;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .held         (held),
        .move         (move),
        .press_tick   (press_tick),
        .press_code   (press_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (press_tick === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty: observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".held"}, {3'b000, held},       {3'b000, e.held});
        chk({e.tag, ".move"}, {5'b00000, move},     {5'b00000, e.mv});
        chk({e.tag, ".tick"}, {7'b0, press_tick},   {7'b0, e.tick});
        chk({e.tag, ".code"}, {5'b00000, press_code}, {5'b00000, e.code});
    endtask

    // Drive one byte, push its expected effect, check it one cycle later.
    task automatic send(input logic [7:0] b, input string tag, input logic [4:0] eh,
                        input logic [2:0] em, input logic et, input logic [2:0] ec);
        exp_t e;
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        e.tag = tag; e.held = eh; e.mv = em; e.tick = et; e.code = ec;
        sb.push_back(e);
        @(negedge clk);
        rx_done_tick = 1'b0;
        compare_front();
    endtask

    initial begin
        int p0;
        resetn       = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst.held", {3'b000, held}, 8'h00);
        chk("rst.move", {5'b0, move}, 8'h00);
        chk("rst.tick", {7'b0, press_tick}, 8'h00);
        chk("rst.code", {5'b0, press_code}, 8'h00);
        resetn = 1'b1;
        @(negedge clk);

        // Basic make / break of W
        send(8'h1D, "w_make",  5'b00001, 3'b001, 1'b1, 3'b001);
        @(negedge clk);
        chk("w_tick_one_cycle", {7'b0, press_tick}, 8'h00);
        send(8'hF0, "w_f0",    5'b00001, 3'b001, 1'b0, 3'b001);
        send(8'h1D, "w_break", 5'b00000, 3'b000, 1'b0, 3'b001);

        // Typematic repeats of A
        p0 = pulses;
        send(8'h1C, "a_make",  5'b00010, 3'b010, 1'b1, 3'b010);
        send(8'h1C, "a_rep1",  5'b00010, 3'b010, 1'b0, 3'b010);
        send(8'h1C, "a_rep2",  5'b00010, 3'b010, 1'b0, 3'b010);
        send(8'h1C, "a_rep3",  5'b00010, 3'b010, 1'b0, 3'b010);
        chk("typematic_pulses", 8'(pulses - p0), 8'd1);
        send(8'hF0, "a_f0",    5'b00010, 3'b010, 1'b0, 3'b010);
        send(8'h1C, "a_break", 5'b00000, 3'b000, 1'b0, 3'b010);

        // Extended up arrow alongside W
        send(8'hE0, "up_e0",    5'b00000, 3'b000, 1'b0, 3'b010);
        send(8'h75, "up_make",  5'b00001, 3'b001, 1'b1, 3'b001);
        send(8'h1D, "w_make2",  5'b00001, 3'b001, 1'b1, 3'b001);
        send(8'hE0, "up_e0b",   5'b00001, 3'b001, 1'b0, 3'b001);
        send(8'hF0, "up_f0",    5'b00001, 3'b001, 1'b0, 3'b001);
        send(8'h75, "up_break", 5'b00001, 3'b001, 1'b0, 3'b001);
        send(8'hF0, "w_f0b",    5'b00001, 3'b001, 1'b0, 3'b001);
        send(8'h1D, "w_break2", 5'b00000, 3'b000, 1'b0, 3'b001);

        // Last-pressed wins, then priority fallback on its release
        send(8'h1B, "s_make",  5'b00100, 3'b011, 1'b1, 3'b011);
        send(8'h23, "d_make",  5'b01100, 3'b100, 1'b1, 3'b100);
        send(8'hF0, "d_f0",    5'b01100, 3'b100, 1'b0, 3'b100);
        send(8'h23, "d_break", 5'b00100, 3'b011, 1'b0, 3'b100);
        send(8'hF0, "s_f0",    5'b00100, 3'b011, 1'b0, 3'b100);
        send(8'h1B, "s_break", 5'b00000, 3'b000, 1'b0, 3'b100);

        // Pending F0 expires; Space then counts as a make
        send(8'hF0, "to_f0",   5'b00000, 3'b000, 1'b0, 3'b100);
        repeat (TO + 2) @(negedge clk);
        send(8'h29, "to_space", 5'b10000, 3'b101, 1'b1, 3'b101);

        // Asynchronous reset mid-sequence
        send(8'hE0, "mid_e0",  5'b10000, 3'b101, 1'b0, 3'b101);
        send(8'hF0, "mid_f0",  5'b10000, 3'b101, 1'b0, 3'b101);
        #2 resetn = 1'b0;
        #1;
        chk("arst.held", {3'b000, held}, 8'h00);
        chk("arst.move", {5'b0, move}, 8'h00);
        chk("arst.code", {5'b0, press_code}, 8'h00);
        @(negedge clk);
        resetn = 1'b1;
        send(8'h75, "post_rst_75",    5'b00000, 3'b000, 1'b0, 3'b000);
        send(8'h29, "post_rst_space", 5'b10000, 3'b101, 1'b1, 3'b101);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits between the PS/2 byte receiver (ps2_rx) and the move decoder. It consumes raw set-2 scan bytes and the rx_done_tick strobe.
- Tracks the make, break (F0) and extended (E0) prefix sequence, and keeps a held-key state for the game keys.
- Produces a stable, registered 3-bit move code and a one-cycle new-press pulse. Typematic repeats are filtered out.
- This replaces the current per-byte decoding, which loses key-held information.

Parameters:
- TIMEOUT_CYCLES, 1_000_000, clk cycles a prefix (E0/F0) may stay pending before it is discarded (20 ms at 50 MHz).
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived, not to be overridden).

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- resetn  in  1  asynchronous, active-low reset
- rx_done_tick  in  1  one-cycle strobe: rx_data holds a new byte
- rx_data  in  8  received scan byte
- held  out  5  key-held bitmap: [0] up, [1] left, [2] down, [3] right, [4] action
- move  out  3  current move code: 001 up, 010 left, 011 down, 100 right, 101 action, 000 none
- press_tick  out  1  one-cycle pulse on a genuine new press of a tracked key
- press_code  out  3  move code of the last new press, held until the next new press

Behaviour:
- Reset (async, resetn=0):
  - held=0, move=000, press_tick=0, press_code=000.
  - FSM goes to IDLE, timeout counter=0, internal key bits cleared.
  - All outputs are registered. Any byte mid-sequence is dropped.
- Key map:
  - WASD (non-extended): W=1D up, A=1C left, S=1B down, D=23 right.
  - Arrows (E0-prefixed): 75 up, 6B left, 72 down, 74 right.
  - Action: Space=29, non-extended.
  - WASD/Space and arrows are tracked in two separate 5-bit internal vectors. held = OR of the two, so releasing W does not clear a held Up arrow.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. The FSM advances only on cycles with rx_done_tick=1.
  - IDLE: E0 goes to GOT_E0; F0 goes to GOT_F0; E1 is ignored (stay IDLE); any other byte is a non-extended make.
  - GOT_E0: F0 goes to GOT_E0F0; E0 stays in GOT_E0; any other byte is an extended make, then return to IDLE.
  - GOT_F0: byte is a non-extended break, then IDLE.
  - GOT_E0F0: byte is an extended break, then IDLE.
  - Unmapped codes make or break nothing but still return the FSM to IDLE. Pause-key bytes are therefore harmless.
- Timeout:
  - The counter resets on every rx_done_tick and increments in any non-IDLE state.
  - At TIMEOUT_CYCLES the FSM returns to IDLE and the pending prefix is discarded.
- Make:
  - If the key bit is already set (typematic repeat), there is no pulse and no change.
  - Otherwise: set the bit, press_tick=1 for exactly one cycle, press_code=code, record it as the last-pressed key.
- Break: clear the bit. A break of a key that is not held is a no-op.
- Latency: a byte tick in cycle N updates held, move, press_tick and press_code in cycle N+1.
- move selection:
  - If the last-pressed key is still held, move = that key.
  - Otherwise, fixed priority over held: up > left > down > right > action.
  - If no key is held, move = 000.
  - The same rule applies when the last key is released while others remain held: move falls back to priority in the same cycle held updates.
- Simultaneous timeout expiry and rx_done_tick in one cycle: the byte wins and is processed in the current state.

Decomposition:
- Package ps2_pkg holds:
  - scan-code constants (SC_E0, SC_F0, SC_E1, SC_W, SC_A, SC_S, SC_D, SC_SPACE, SC_UP, SC_LEFT, SC_DOWN, SC_RIGHT);
  - move-code constants (MV_NONE through MV_ACTION);
  - the FSM state enum.
- One sub-module, ps2_keymap: a combinational map from {extended, byte} to {hit, 3-bit code, 5-bit one-hot}. It is shared with move_control later.

Test Plan:
- Reset held low, then bytes 1D, F0 1D → press_tick pulse in the cycle after 1D, press_code=001, move=001; after the F0 1D break, held=00000 and move=000.
- Typematic: 1C sent 4 times → exactly one press_tick, held=00010, move=010.
- Extended: E0 75 then 1D → held=00001 after both; send E0 F0 75 → held stays 00001 (W still held), move=001.
- Fallback: press 1B, then 23 → move=100; release 23 → move=011 in the cycle held updates.
- Timeout: F0, idle TIMEOUT_CYCLES+2 cycles, then 29 → treated as a make: press_tick, press_code=101, held=10000.
- Assert resetn=0 mid-sequence (after E0 F0) → outputs are zero immediately (async); after release, byte 75 is a non-extended unmapped make → no change.
